des_encrypt_unrolled: RTL and testbench
=======================================

Name: des_encrypt_unrolled

Overview:
Single-block DES encryption engine with all 16 Feistel rounds unrolled into one combinational datapath between an input register stage and an output register. The key schedule is computed outside this block; it receives 16 precomputed 48-bit round keys. It sits behind a controller or testbench that issues one block per start pulse and collects the result on done.

Parameters:
None. Round count (16) and widths (64/48/768) are fixed constants in the shared package.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request; samples message and round_keys
message  input  64 [1:64]  plaintext block; bit 1 is the MSB (FIPS 46 numbering)
round_keys  input  768 [1:768]  K1 in bits 1:48, K2 in bits 49:96, ..., K16 in bits 721:768
done  output  1  one-cycle pulse when result is valid
result  output  64 [1:64]  ciphertext, same bit numbering as message

Behaviour:
- Reset (rst=1 at a clk edge): done=0, result=64'h0, internal input registers cleared. Reset overrides a simultaneous start.
- Edge N with start=1: message and round_keys are captured into input registers.
- During cycle N+1, the combinational path computes the DES datapath in this order: IP; 16 rounds (L_i=R_{i-1}; R_i=L_{i-1} XOR f(R_{i-1},K_i)); final swap R16||L16; FP (IP^-1).
- f function: E expansion 32->48; XOR with K_i; S1..S8 (6->4 each; row from bits 1 and 6, column from bits 2-5); P permutation.
- Edge N+1: result is loaded from the datapath and done=1.
- Edge N+2: done returns to 0 unless start was high at edge N+1.
- Latency is 2 edges from start to done. result stays stable after done until the next completion or reset.
- Back-to-back operation: start may be asserted every cycle. Each start produces exactly one done two edges later. Throughput is one block per cycle.
- start=0: input registers hold their previous values, and result is not updated.
- Inputs are don't-care when start=0.
- No busy or ready signal; the block never stalls.

Optional Feature:
DES_DECRYPT_EN
- Defined: adds input port decrypt (1 bit), sampled with start. When decrypt=1, the round keys are applied in reverse order (K16 in round 1 ... K1 in round 16), so the output is DES decryption with the same round_keys vector. Latency and handshake are unchanged.
- Undefined: the port does not exist and the block only encrypts.

Decomposition:
Package des_pkg holds:
- IP, FP, E and P permutation tables
- the eight S-box tables
- constants DES_ROUNDS=16, DES_BLOCK_W=64, DES_SUBKEY_W=48

One sub-module, des_round: combinational, takes L, R and a 48-bit subkey, and returns the next L and R. Instantiate it 16 times in a generate loop; IP, FP and the final swap stay in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 -> done=0 and result=0 throughout; release rst -> no spurious done.
- All-zero: round_keys=0 (key 0000000000000000), message=0000000000000000, start pulse -> two edges later done=1 for exactly one cycle, result=8CA64DE9C1B123A7.
- All-ones: round_keys all 1s (key FFFFFFFFFFFFFFFF), message=FFFFFFFFFFFFFFFF -> result=7359B2163E4EDC58.
- FIPS example: key 133457799BBCDFF1 expanded by the standard key schedule (K1=1B02EFFC7072 ... K16=CB3D8B0E17F5), message=0123456789ABCDEF -> result=85E813540F0AB405.
- Back-to-back: start high for 3 consecutive cycles with the three vectors above -> done high for 3 consecutive cycles, results in issue order; result holds the last value after done falls.
- Reset mid-operation: start, then rst=1 on the next edge -> no done, result=0. With DES_DECRYPT_EN defined: FIPS keys, message=85E813540F0AB405, decrypt=1 -> result=0123456789ABCDEF.

Source files
------------

// File: rtl/des_pkg.sv
// DES constants, permutation tables, S-boxes and permutation helpers.
// Tables use FIPS 46 1-based bit numbering; bit 1 maps to vector index [W-1].
package des_pkg;

  localparam int DES_ROUNDS   = 16;
  localparam int DES_BLOCK_W  = 64;
  localparam int DES_SUBKEY_W = 48;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,
    60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,
    64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,
    59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,
    63, 55, 47, 39, 31, 23, 15, 7
  };

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Row-major: index = row*16 + col
  localparam logic [3:0] SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
    return y;
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, K).
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l_i,
  input  logic [31:0] r_i,
  input  logic [47:0] k_i,
  output logic [31:0] l_o,
  output logic [31:0] r_o
);

  logic [47:0] x;
  logic [31:0] sb;
  logic [5:0]  six;

  always_comb begin
    x   = e_exp(r_i) ^ k_i;
    sb  = '0;
    six = '0;
    // Row from outer bits 1 and 6, column from bits 2..5
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      sb[31-4*s -: 4] = SBOX[s][{six[5], six[0], six[4:1]}];
    end
    l_o = r_i;
    r_o = l_i ^ p_perm(sb);
  end

endmodule

// File: rtl/des_encrypt_unrolled.sv
// Fully unrolled 16-round DES engine, two-edge latency, one block per cycle.
// Optional DES_DECRYPT_EN adds a decrypt input that reverses round-key order.
module des_encrypt_unrolled
  import des_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [63:0]   message,
  input  logic [767:0]  round_keys,
`ifdef DES_DECRYPT_EN
  input  logic          decrypt,
`endif
  output logic          done,
  output logic [63:0]   result
);

  logic [63:0]  msg_q, msg_d;
  logic [767:0] keys_q, keys_d;
  logic         vld_q, vld_d;
  logic         done_q, done_d;
  logic [63:0]  result_q, result_d;
`ifdef DES_DECRYPT_EN
  logic         dec_q, dec_d;
`endif

  logic [63:0] ip_blk;
  logic [63:0] dp_out;

  assign ip_blk = ip_perm(msg_q);

  for (genvar g = 0; g < DES_ROUNDS; g++) begin : g_rnd
    logic [31:0] l_in, r_in, l_out, r_out;
    logic [47:0] k_sel;
    if (g == 0) begin : g_first
      assign l_in = ip_blk[63:32];
      assign r_in = ip_blk[31:0];
    end else begin : g_next
      assign l_in = g_rnd[g-1].l_out;
      assign r_in = g_rnd[g-1].r_out;
    end
`ifdef DES_DECRYPT_EN
    assign k_sel = dec_q ? keys_q[767-48*(15-g) -: 48]
                         : keys_q[767-48*g -: 48];
`else
    assign k_sel = keys_q[767-48*g -: 48];
`endif
    des_round u_round (
      .l_i (l_in),
      .r_i (r_in),
      .k_i (k_sel),
      .l_o (l_out),
      .r_o (r_out)
    );
  end

  // Final swap R16||L16 before the inverse permutation
  assign dp_out = fp_perm({g_rnd[15].r_out, g_rnd[15].l_out});

  always_comb begin
    vld_d    = start;
    msg_d    = start ? message : msg_q;
    keys_d   = start ? round_keys : keys_q;
    done_d   = vld_q;
    result_d = vld_q ? dp_out : result_q;
`ifdef DES_DECRYPT_EN
    dec_d    = start ? decrypt : dec_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q    <= '0;
      keys_q   <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef DES_DECRYPT_EN
      dec_q    <= 1'b0;
`endif
    end else begin
      msg_q    <= msg_d;
      keys_q   <= keys_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef DES_DECRYPT_EN
      dec_q    <= dec_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_des_encrypt_unrolled.sv
// Self-checking bench for des_encrypt_unrolled: known-answer table,
// hand sequences for reset/back-to-back, and a randomized bit-level model.
module tb_des_encrypt_unrolled;
  import des_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [63:0]  message;
  logic [767:0] round_keys;
  logic         decrypt;
  logic         done;
  logic [63:0]  result;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  des_encrypt_unrolled dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .message    (message),
    .round_keys (round_keys),
`ifdef DES_DECRYPT_EN
    .decrypt    (decrypt),
`endif
    .done       (done),
    .result     (result)
  );

  typedef struct {
    string        name;
    logic [63:0]  msg;
    logic [767:0] keys;
    bit           dec;
    logic [63:0]  exp;
  } vec_t;

  localparam logic [767:0] FIPS_KEYS = {
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  // Bit-list model: FIPS bit n is element n-1 of each array.
  function automatic logic [63:0] des_model(input logic [63:0] m,
                                            input logic [767:0] rk,
                                            input bit dec);
    bit blk[64], pre[64], l[32], r[32], f[32], s[32], nr[32], xe[48];
    logic [63:0] res;
    int row, col, v, k;
    for (int i = 0; i < 64; i++) blk[i] = m[63-i];
    for (int i = 0; i < 32; i++) begin
      l[i] = blk[IP_T[i]-1];
      r[i] = blk[IP_T[32+i]-1];
    end
    for (int rd = 0; rd < 16; rd++) begin
      k = dec ? 15 - rd : rd;
      for (int j = 0; j < 48; j++) xe[j] = r[E_T[j]-1] ^ rk[767-48*k-j];
      for (int sb = 0; sb < 8; sb++) begin
        row = 2*int'(xe[6*sb]) + int'(xe[6*sb+5]);
        col = 8*int'(xe[6*sb+1]) + 4*int'(xe[6*sb+2])
            + 2*int'(xe[6*sb+3]) + int'(xe[6*sb+4]);
        v = int'(SBOX[sb][16*row+col]);
        for (int t = 0; t < 4; t++) s[4*sb+t] = bit'((v >> (3-t)) & 1);
      end
      for (int j = 0; j < 32; j++) f[j] = s[P_T[j]-1];
      for (int j = 0; j < 32; j++) nr[j] = l[j] ^ f[j];
      l = r;
      r = nr;
    end
    for (int i = 0; i < 32; i++) begin
      pre[i]    = r[i];
      pre[32+i] = l[i];
    end
    for (int i = 0; i < 64; i++) res[63-i] = pre[FP_T[i]-1];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input vec_t v);
    start      = 1'b1;
    message    = v.msg;
    round_keys = v.keys;
    decrypt    = v.dec;
  endtask

  vec_t kat[$];
  logic [63:0] last_res;
  bit          pend_s;
  logic [63:0] pend_e;

  initial begin
    vec_t v;
    kat.push_back('{"zero", 64'h0, {768{1'b0}}, 1'b0, 64'h8CA64DE9C1B123A7});
    kat.push_back('{"ones", {64{1'b1}}, {768{1'b1}}, 1'b0, 64'h7359B2163E4EDC58});
    kat.push_back('{"fips", 64'h0123456789ABCDEF, FIPS_KEYS, 1'b0,
                    64'h85E813540F0AB405});
`ifdef DES_DECRYPT_EN
    kat.push_back('{"fips_dec", 64'h85E813540F0AB405, FIPS_KEYS, 1'b1,
                    64'h0123456789ABCDEF});
`endif

    rst = 1'b1;
    issue(kat[2]);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", result, 64'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_done", 64'(done), 64'd0);
    end

    foreach (kat[i]) begin
      issue(kat[i]);
      step();
      chk({kat[i].name, "_lat"}, 64'(done), 64'd0);
      start = 1'b0;
      step();
      chk({kat[i].name, "_done"}, 64'(done), 64'd1);
      chk(kat[i].name, result, kat[i].exp);
      step();
      chk({kat[i].name, "_done_fall"}, 64'(done), 64'd0);
      chk({kat[i].name, "_hold"}, result, kat[i].exp);
    end

    issue(kat[0]);
    step();
    issue(kat[1]);
    step();
    chk("b2b_done0", 64'(done), 64'd1);
    chk("b2b_res0", result, kat[0].exp);
    issue(kat[2]);
    step();
    chk("b2b_done1", 64'(done), 64'd1);
    chk("b2b_res1", result, kat[1].exp);
    start = 1'b0;
    step();
    chk("b2b_done2", 64'(done), 64'd1);
    chk("b2b_res2", result, kat[2].exp);
    step();
    chk("b2b_fall", 64'(done), 64'd0);
    chk("b2b_hold", result, kat[2].exp);

    issue(kat[2]);
    step();
    start = 1'b0;
    rst   = 1'b1;
    step();
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_after", 64'(done), 64'd0);

    last_res = 64'd0;
    pend_s   = 1'b0;
    pend_e   = 64'd0;
    for (int c = 0; c < 300; c++) begin
      bit s;
      logic [63:0] e;
      s = ($urandom_range(0, 3) != 0);
      v.name = "rand";
      v.msg  = {$urandom, $urandom};
      for (int w = 0; w < 24; w++) v.keys[32*w +: 32] = $urandom;
`ifdef DES_DECRYPT_EN
      v.dec = 1'($urandom_range(0, 1));
`else
      v.dec = 1'b0;
`endif
      e = des_model(v.msg, v.keys, v.dec);
      issue(v);
      start = s;
      step();
      chk("rand_done", 64'(done), 64'(pend_s));
      if (pend_s) last_res = pend_e;
      chk("rand_result", result, last_res);
      pend_s = s;
      pend_e = e;
    end
    start = 1'b0;
    step();
    chk("rand_tail_done", 64'(done), 64'(pend_s));
    if (pend_s) last_res = pend_e;
    chk("rand_tail_result", result, last_res);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
